// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_pkg
// Brief    : Shared state encoding and round-robin helpers for rr_handshake_arbiter.
// Revision : 1.0
// ============================================================================
package rr_arb_pkg;

    localparam int c_MAX_SRC  = 16;
    localparam int c_MAX_ID_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DELIVER = 2'd2
    } state_t;

    typedef struct packed {
        logic                  found;
        logic [c_MAX_ID_W-1:0] idx;
    } grant_t;

    // Wait counter only needs to reach TIMEOUT-1.
    function automatic int wait_cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

    // First set bit of mask after pointer, wrapping modulo num_src.
    function automatic grant_t next_grant(input logic [c_MAX_ID_W-1:0] pointer,
                                          input logic [c_MAX_SRC-1:0]  mask,
                                          input int                    num_src);
        grant_t g;
        int     idx;
        g = '0;
        // Walk from the farthest candidate inwards so the nearest one wins.
        for (int k = c_MAX_SRC; k >= 1; k--) begin
            if (k <= num_src) begin
                idx = int'(pointer) + k;
                if (idx >= num_src) begin
                    idx = idx - num_src;
                end
                if (mask[4'(idx)]) begin
                    g.found = 1'b1;
                    g.idx   = 4'(idx);
                end
            end
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pointer_select.sv
`default_nettype none
// ============================================================================
// Module   : rr_pointer_select
// Brief    : Combinational rotate-priority encoder: next enabled source after ptr.
// Revision : 1.0
// ============================================================================
module rr_pointer_select
    import rr_arb_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic [NUM_SRC-1:0]  mask,
    output logic [ID_WIDTH-1:0] sel,
    output logic                found
);

    grant_t w_grant;

    assign w_grant = next_grant(c_MAX_ID_W'(ptr), c_MAX_SRC'(mask), NUM_SRC);
    assign sel     = ID_WIDTH'(w_grant.idx);
    assign found   = w_grant.found;

endmodule
`default_nettype wire

// File: rtl/rr_handshake_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_handshake_arbiter
// Brief    : Round-robin merge of NUM_SRC req/ack producers onto one consumer.
//            Define RR_ARB_GRANT_COUNT_EN to add per-source delivery counters.
// Revision : 1.0
// ============================================================================
module rr_handshake_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter int TIMEOUT    = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_en,
    output logic [NUM_SRC-1:0]            src_req,
    input  logic [NUM_SRC-1:0]            src_ack,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_din,
    input  logic                          dst_req,
    output logic                          dst_ack,
    output logic [DATA_WIDTH-1:0]         dst_dout,
    output logic [ID_WIDTH-1:0]           dst_src_id,
    output logic                          timeout_pulse,
    output logic                          stray_ack
`ifdef RR_ARB_GRANT_COUNT_EN
    ,
    output logic [NUM_SRC*32-1:0]         grant_count
`endif
);

    localparam int                 c_CNT_W      = wait_cnt_width(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST  = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit                 c_TIMEOUT_EN = (TIMEOUT > 0);

    state_t                  r_state,   w_state;
    logic [ID_WIDTH-1:0]     r_ptr,     w_ptr;
    logic [ID_WIDTH-1:0]     r_sel,     w_sel;
    logic [ID_WIDTH-1:0]     r_id,      w_id;
    logic [ID_WIDTH-1:0]     r_dst_id,  w_dst_id;
    logic [NUM_SRC-1:0]      r_src_req, w_src_req;
    logic [c_CNT_W-1:0]      r_wait,    w_wait;
    logic [DATA_WIDTH-1:0]   r_data,    w_data;
    logic [DATA_WIDTH-1:0]   r_dout,    w_dout;
    logic                    r_dst_ack, w_dst_ack;
    logic                    r_timeout, w_timeout;
    logic                    r_stray,   w_stray;

    logic [ID_WIDTH-1:0]     w_grant_sel;
    logic                    w_grant_found;
    logic                    w_sel_ack;
    logic [DATA_WIDTH-1:0]   w_din [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign w_din[gi] = src_din[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pointer_select #(
        .NUM_SRC  (NUM_SRC),
        .ID_WIDTH (ID_WIDTH)
    ) u_pointer_select (
        .ptr   (r_ptr),
        .mask  (src_en),
        .sel   (w_grant_sel),
        .found (w_grant_found)
    );

    // r_src_req is one-hot on sel in REQ and zero elsewhere, so it doubles as the
    // "who may ack now" mask for both the real ack and stray detection.
    assign w_sel_ack = |(src_ack & r_src_req);

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_sel     = r_sel;
        w_id      = r_id;
        w_dst_id  = r_dst_id;
        w_src_req = r_src_req;
        w_wait    = r_wait;
        w_data    = r_data;
        w_dout    = r_dout;
        w_dst_ack = r_dst_ack;
        w_timeout = 1'b0;
        w_stray   = r_stray | (|(src_ack & ~r_src_req));

        case (r_state)
            IDLE: begin
                if (dst_req && w_grant_found) begin
                    w_sel                  = w_grant_sel;
                    w_src_req              = '0;
                    w_src_req[w_grant_sel] = 1'b1;
                    w_wait                 = '0;
                    w_state                = REQ;
                end
            end
            REQ: begin
                if (w_sel_ack) begin
                    w_data    = w_din[r_sel];
                    w_id      = r_sel;
                    w_src_req = '0;
                    w_ptr     = r_sel;
                    w_state   = DELIVER;
                end else if (c_TIMEOUT_EN && (r_wait == c_WAIT_LAST)) begin
                    w_src_req = '0;
                    w_timeout = 1'b1;
                    w_ptr     = r_sel;
                    w_state   = IDLE;
                end else begin
                    w_wait = r_wait + c_CNT_W'(1);
                end
            end
            DELIVER: begin
                if (r_dst_ack) begin
                    w_dst_ack = 1'b0;
                    w_state   = IDLE;
                end else if (dst_req) begin
                    w_dst_ack = 1'b1;
                    w_dout    = r_data;
                    w_dst_id  = r_id;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= ID_WIDTH'(NUM_SRC - 1);
            r_sel     <= '0;
            r_id      <= '0;
            r_dst_id  <= '0;
            r_src_req <= '0;
            r_wait    <= '0;
            r_data    <= '0;
            r_dout    <= '0;
            r_dst_ack <= 1'b0;
            r_timeout <= 1'b0;
            r_stray   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_sel     <= w_sel;
            r_id      <= w_id;
            r_dst_id  <= w_dst_id;
            r_src_req <= w_src_req;
            r_wait    <= w_wait;
            r_data    <= w_data;
            r_dout    <= w_dout;
            r_dst_ack <= w_dst_ack;
            r_timeout <= w_timeout;
            r_stray   <= w_stray;
        end
    end

    assign src_req       = r_src_req;
    assign dst_ack       = r_dst_ack;
    assign dst_dout      = r_dout;
    assign dst_src_id    = r_dst_id;
    assign timeout_pulse = r_timeout;
    assign stray_ack     = r_stray;

`ifdef RR_ARB_GRANT_COUNT_EN
    logic w_deliver_fire;

    assign w_deliver_fire = (r_state == DELIVER) && !r_dst_ack && dst_req;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_grant_cnt
            logic [31:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_deliver_fire && (r_id == ID_WIDTH'(gi))) begin
                    r_cnt <= r_cnt + 32'd1;
                end
            end
            assign grant_count[gi*32 +: 32] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: doc/rr_handshake_arbiter.md
Name: rr_handshake_arbiter

Overview:
- Round-robin arbiter that merges NUM_SRC req/ack producer streams into one req/ack consumer port.
- Each source behaves as a `producer`, or as the upstream side of an async_operator: it sees req, returns a one-cycle ack with data.
- The single destination behaves as a consumer, or as an async_operator input: it drives req and expects an ack pulse with data.
- Use: sharing one operator input, or one testbench consumer, among several dataflow outputs; each delivery is tagged with its source index.

Parameters:
- NUM_SRC, 4, number of source ports (2..16).
- DATA_WIDTH, 32, data width per source.
- ID_WIDTH, 2, width of the source tag; must satisfy 2**ID_WIDTH >= NUM_SRC.
- TIMEOUT, 0, cycles to wait for a source ack before abandoning it; 0 waits forever.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- src_en  in  NUM_SRC  per-source enable mask, sampled only in IDLE.
- src_req  out  NUM_SRC  request to source i; at most one bit high (one-hot or zero).
- src_ack  in  NUM_SRC  one-cycle ack from source i.
- src_din  in  NUM_SRC*DATA_WIDTH  source data; slice i is bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- dst_req  in  1  destination request.
- dst_ack  out  1  one-cycle ack to destination.
- dst_dout  out  DATA_WIDTH  delivered data, valid while dst_ack=1 and held afterwards.
- dst_src_id  out  ID_WIDTH  index of the source that supplied dst_dout.
- timeout_pulse  out  1  one-cycle pulse when a source is abandoned.
- stray_ack  out  1  sticky flag: an ack arrived from a source not currently requested.

Behaviour:
- Reset values: src_req=0, dst_ack=0, dst_dout=0, dst_src_id=0, timeout_pulse=0, stray_ack=0; state=IDLE; pointer=NUM_SRC-1, so the first grant goes to source 0.
- Reset mid-transaction drops src_req and dst_ack on the next edge; any held data is discarded.
- State machine: IDLE, REQ, DELIVER.
- IDLE:
  - Leaves IDLE when dst_req=1 and |src_en.
  - sel = first index with src_en set, searching from pointer+1 modulo NUM_SRC, wrapping.
  - The same edge sets src_req[sel]=1 and goes to REQ.
  - If src_en==0, stays in IDLE regardless of dst_req.
- REQ:
  - src_req[sel] held high; wait counter increments every cycle.
  - On src_ack[sel]=1: latch src_din slice sel into the data register, sel into the id register, clear src_req, set pointer=sel, go to DELIVER. src_req therefore falls one cycle after ack, so the source never double-acks.
  - If TIMEOUT>0 and the wait counter reaches TIMEOUT-1 without ack: clear src_req, pulse timeout_pulse, set pointer=sel (source skipped next round), go to IDLE.
  - An ack arriving on the same cycle as timeout expiry wins; no timeout pulse is produced.
- DELIVER:
  - When dst_req=1 and dst_ack=0: dst_ack<=1, dst_dout<=data register, dst_src_id<=id register; next cycle dst_ack<=0 and go to IDLE.
  - If dst_req is low, hold the data and wait indefinitely; no data is lost.
- dst_ack is never high on two consecutive cycles.
- Latency, all sources always-ready: dst_req seen at edge t; src_req high after t; source ack after t+1; data latched at t+2; dst_ack high after t+3; IDLE re-entered at t+4. One word per 5 cycles.
- Any src_ack[j] with j != sel, or any ack while not in REQ, sets stray_ack; it stays set until rst. Such acks never alter state or data.
- The wait counter is wide enough for TIMEOUT and clears on entering REQ.
- Round-robin: every source enabled during N consecutive grant decisions is granted once per N grants.

Optional Feature:
- Macro: RR_ARB_GRANT_COUNT_EN.
- When defined: extra output grant_count, NUM_SRC*32 bits. 32-bit counter i increments on each completed delivery from source i, wraps at 2^32, and clears on rst. Timeouts do not count.
- When undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package rr_arb_pkg:
  - state enum {IDLE, REQ, DELIVER};
  - localparam-style helper constant for counter width;
  - function next_grant(pointer, mask, NUM_SRC) returning the index and a found bit.
- Sub-module rr_pointer_select (combinational rotate-priority-encoder) is natural; all sequencing stays in rr_handshake_arbiter.

Test Plan:
- NUM_SRC=4, all enabled, four always-ready producers, dst_req constant 1 → dst_src_id sequence 0,1,2,3,0,1…; dst_ack period 5 cycles; data values per source increment by 1.
- src_en=4'b0101 → grants alternate 0,2,0,2; src_req[1] and src_req[3] never asserted.
- TIMEOUT=8, source 1 never acks → src_req[1] high exactly 8 cycles; timeout_pulse once; next grant to source 2; no dst_ack for source 1.
- Destination stalls: dst_req low for 20 cycles after data latched → no dst_ack; when dst_req returns, single dst_ack with the held value and correct id.
- Source 3 acks while sel=0 → stray_ack=1 and stays set; source 0's data is delivered unaffected.
- rst asserted while in REQ → next edge src_req=0, dst_ack=0; after release, first grant goes to source 0.
